// File: rtl/aer_array_readout.sv
// rtl/aer_array_readout.sv - event-camera array readout: round-robin row/column arbitration into an AER event FIFO
module aer_array_readout #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int POL_W      = 2,
  parameter int TS_W       = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int ROW_AW    = $clog2(ROWS),
  localparam int COL_AW    = $clog2(COLS),
  localparam int EV_W      = ROW_AW + COL_AW + 1 + TS_W,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        enable_i,
  input  logic [ROWS*COLS*POL_W-1:0]  req_i,
  output logic [ROWS*COLS-1:0]        gnt_o,
  output logic                        ev_valid_o,
  input  logic                        ev_ready_i,
  output logic [EV_W-1:0]             ev_data_o,
  output logic [LVL_W-1:0]            fifo_level_o,
  output logic                        busy_o
);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int ROW_SW  = ROW_AW + 1;
  localparam int COL_SW  = COL_AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ROW_SEL, S_COL_SEL} state_t;
  state_t r_state, w_state_nxt;

  logic [TS_W-1:0]      r_ts;
  logic [ROW_AW-1:0]    r_row, r_row_ptr;
  logic [COL_AW-1:0]    r_col_ptr;
  logic [COLS-1:0]      r_served;
  logic [ROWS*COLS-1:0] r_gnt;

  logic [COLS-1:0]      w_pix_req [ROWS];
  logic [COLS-1:0]      w_pix_on  [ROWS];
  logic [ROWS-1:0]      w_row_req;

  always_comb begin
    w_row_req = '0;
    for (int r = 0; r < ROWS; r++) begin
      w_pix_req[r] = '0;
      w_pix_on[r]  = '0;
      for (int c = 0; c < COLS; c++) begin
        w_pix_req[r][c] = |req_i[(r*COLS+c)*POL_W +: POL_W];
        w_pix_on[r][c]  = req_i[(r*COLS+c)*POL_W];
      end
      w_row_req[r] = |w_pix_req[r];
    end
  end

  // Row arbiter: scan from the pointer upward, wrapping modulo ROWS
  logic [ROW_SW-1:0] w_row_sum;
  logic [ROW_AW-1:0] w_row_idx, w_row_win, w_row_ptr_nxt;
  logic              w_row_found;

  always_comb begin
    w_row_found = 1'b0;
    w_row_win   = '0;
    w_row_sum   = '0;
    w_row_idx   = '0;
    for (int i = 0; i < ROWS; i++) begin
      w_row_sum = {1'b0, r_row_ptr} + ROW_SW'(i);
      w_row_idx = (w_row_sum >= ROW_SW'(ROWS)) ? ROW_AW'(w_row_sum - ROW_SW'(ROWS)) : ROW_AW'(w_row_sum);
      if (!w_row_found && w_row_req[w_row_idx]) begin
        w_row_found = 1'b1;
        w_row_win   = w_row_idx;
      end
    end
    w_row_ptr_nxt = (w_row_win == ROW_AW'(ROWS-1)) ? '0 : w_row_win + 1'b1;
  end

  // Column arbiter over the latched row, excluding pixels already served this visit
  logic [COLS-1:0]   w_cand;
  logic [COL_SW-1:0] w_col_sum;
  logic [COL_AW-1:0] w_col_idx, w_col_win, w_col_ptr_nxt;
  logic              w_col_found;
  logic              w_pol;

  always_comb begin
    w_cand      = w_pix_req[r_row] & ~r_served;
    w_col_found = 1'b0;
    w_col_win   = '0;
    w_col_sum   = '0;
    w_col_idx   = '0;
    for (int i = 0; i < COLS; i++) begin
      w_col_sum = {1'b0, r_col_ptr} + COL_SW'(i);
      w_col_idx = (w_col_sum >= COL_SW'(COLS)) ? COL_AW'(w_col_sum - COL_SW'(COLS)) : COL_AW'(w_col_sum);
      if (!w_col_found && w_cand[w_col_idx]) begin
        w_col_found = 1'b1;
        w_col_win   = w_col_idx;
      end
    end
    w_col_ptr_nxt = (w_col_win == COL_AW'(COLS-1)) ? '0 : w_col_win + 1'b1;
    w_pol         = w_pix_on[r_row][w_col_win];
  end

  logic [EV_W-1:0]    r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic               w_full, w_pop, w_push, w_row_take;
  logic [EV_W-1:0]    w_ev;
  logic [ROWS*COLS-1:0] w_gnt_nxt;

  assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop     = (r_level != '0) && ev_ready_i;
  assign w_ev      = {r_row, w_col_win, w_pol, r_ts};
  assign w_gnt_nxt = (ROWS*COLS)'(1) << (int'(r_row) * COLS + int'(w_col_win));

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_row_take  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable_i) w_state_nxt = S_ROW_SEL;
      end
      S_ROW_SEL: begin
        if (!enable_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_row_found) begin
          w_row_take  = 1'b1;
          w_state_nxt = S_COL_SEL;
        end
      end
      S_COL_SEL: begin
        if (!enable_i) begin
          w_state_nxt = S_IDLE;
        end else if (!w_col_found) begin
          w_state_nxt = S_ROW_SEL;
        end else if (!w_full) begin
          w_push = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_ts      <= '0;
      r_row     <= '0;
      r_row_ptr <= '0;
      r_col_ptr <= '0;
      r_served  <= '0;
      r_gnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ts    <= r_ts + 1'b1;
      r_gnt   <= w_push ? w_gnt_nxt : '0;
      if (w_row_take) begin
        r_row     <= w_row_win;
        r_row_ptr <= w_row_ptr_nxt;
        r_served  <= '0;
      end
      if (w_push) begin
        r_served[w_col_win] <= 1'b1;
        r_col_ptr           <= w_col_ptr_nxt;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= w_ev;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Head is masked when empty so stale storage never appears on the bus
  assign gnt_o        = r_gnt;
  assign ev_valid_o   = (r_level != '0);
  assign ev_data_o    = ev_valid_o ? r_mem[r_rd_ptr] : '0;
  assign fifo_level_o = r_level;
  assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_aer_array_readout.sv
// tb/tb_aer_array_readout.sv - directed and randomized checks of aer_array_readout against a behavioural model
module tb_aer_array_readout;
  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int POL_W  = 2;
  localparam int TS_W   = 10;
  localparam int DEPTH  = 4;
  localparam int ROW_AW = 3;
  localparam int COL_AW = 3;
  localparam int EV_W   = ROW_AW + COL_AW + 1 + TS_W;
  localparam int LVL_W  = 3;

  logic                       clk_i, reset_i, enable_i, ev_ready_i;
  logic [ROWS*COLS*POL_W-1:0] req_i;
  logic [ROWS*COLS-1:0]       gnt_o;
  logic                       ev_valid_o, busy_o;
  logic [EV_W-1:0]            ev_data_o;
  logic [LVL_W-1:0]           fifo_level_o;

  aer_array_readout #(
    .ROWS(ROWS), .COLS(COLS), .POL_W(POL_W), .TS_W(TS_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .req_i(req_i),
    .gnt_o(gnt_o), .ev_valid_o(ev_valid_o), .ev_ready_i(ev_ready_i),
    .ev_data_o(ev_data_o), .fifo_level_o(fifo_level_o), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 idle, 1 choosing a row, 2 serving the chosen row
  int              m_mode, m_row, m_rptr, m_cptr, m_ts, m_gnt;
  bit [COLS-1:0]   m_served;
  logic [EV_W-1:0] m_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [POL_W-1:0] pix(input int r, input int c);
    return req_i[(r*COLS+c)*POL_W +: POL_W];
  endfunction

  task automatic set_pix(input int r, input int c, input logic [POL_W-1:0] v);
    req_i[(r*COLS+c)*POL_W +: POL_W] = v;
  endtask

  function automatic int onehot_idx(input logic [ROWS*COLS-1:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < ROWS*COLS; i++)
      if (v[i]) idx = (idx == -1) ? i : -2;
    return idx;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_row = 0; m_rptr = 0; m_cptr = 0; m_ts = 0; m_gnt = -1;
    m_served = '0;
    m_q.delete();
  endtask

  task automatic model_step();
    int              nq, found, r, c;
    bit              do_pop, full, push, any;
    logic [POL_W-1:0] p;
    logic [EV_W-1:0] ev;
    nq     = m_q.size();
    do_pop = (nq > 0) && ev_ready_i;
    full   = (nq == DEPTH);
    push   = 1'b0;
    ev     = '0;
    m_gnt  = -1;
    if (m_mode == 0) begin
      if (enable_i) m_mode = 1;
    end else if (!enable_i) begin
      m_mode = 0;
    end else if (m_mode == 1) begin
      for (int k = 0; k < ROWS; k++) begin
        r = (m_rptr + k) % ROWS;
        any = 1'b0;
        for (int cc = 0; cc < COLS; cc++) if (pix(r, cc) != 0) any = 1'b1;
        if (any) begin
          m_row = r; m_rptr = (r + 1) % ROWS; m_served = '0; m_mode = 2;
          break;
        end
      end
    end else begin
      found = -1;
      for (int k = 0; k < COLS; k++) begin
        c = (m_cptr + k) % COLS;
        if (pix(m_row, c) != 0 && !m_served[c]) begin
          found = c;
          break;
        end
      end
      if (found < 0) begin
        m_mode = 1;
      end else if (!full) begin
        p    = pix(m_row, found);
        ev   = {ROW_AW'(m_row), COL_AW'(found), p[0], TS_W'(m_ts)};
        push = 1'b1;
        m_served[found] = 1'b1;
        m_cptr = (found + 1) % COLS;
        m_gnt  = m_row * COLS + found;
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (push) m_q.push_back(ev);
    m_ts = (m_ts + 1) % (1 << TS_W);
  endtask

  task automatic check_all();
    chk("valid", ev_valid_o, (m_q.size() != 0));
    chk("data",  ev_data_o, (m_q.size() != 0) ? m_q[0] : '0);
    chk("level", fifo_level_o, m_q.size());
    chk("busy",  busy_o, (m_mode != 0));
    chk("gnt",   gnt_o, (m_gnt < 0) ? 64'd0 : (64'd1 << m_gnt));
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    check_all();
  endtask

  task automatic do_reset(input string tag);
    reset_i = 1'b1; enable_i = 1'b0; ev_ready_i = 1'b0; req_i = '0;
    #1;
    model_reset();
    chk({tag, "_rst_valid"}, ev_valid_o, 0);
    chk({tag, "_rst_data"},  ev_data_o, 0);
    chk({tag, "_rst_level"}, fifo_level_o, 0);
    chk({tag, "_rst_gnt"},   gnt_o, 0);
    chk({tag, "_rst_busy"},  busy_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  initial begin
    int g, gcnt, pops, idx;
    logic [COLS-1:0] ymask;

    do_reset("init");
    enable_i = 1'b1; set_pix(2, 5, 2'b01);
    repeat (3) tick();
    chk("single_gnt",   gnt_o, 64'd1 << 21);
    chk("single_data",  ev_data_o, {3'd2, 3'd5, 1'b1, 10'd2});
    chk("single_valid", ev_valid_o, 1);
    chk("single_level", fifo_level_o, 1);
    req_i = '0; ev_ready_i = 1'b1;
    repeat (4) tick();

    do_reset("row");
    enable_i = 1'b1; set_pix(1, 3, 2'b10); set_pix(1, 6, 2'b01);
    repeat (3) tick();
    chk("row_gnt0", gnt_o, 64'd1 << 11);
    tick();
    chk("row_gnt1", gnt_o, 64'd1 << 14);
    chk("row_head", ev_data_o, {3'd1, 3'd3, 1'b0, 10'd2});
    req_i = '0;
    tick();
    chk("row_no_dup", gnt_o, 0);
    chk("row_level",  fifo_level_o, 2);
    ev_ready_i = 1'b1;
    tick();
    chk("row_second", ev_data_o, {3'd1, 3'd6, 1'b1, 10'd3});
    repeat (3) tick();

    do_reset("fair");
    enable_i = 1'b1; ev_ready_i = 1'b1; set_pix(0, 0, 2'b01); set_pix(4, 0, 2'b11);
    g = 0;
    for (int k = 0; k < 30 && g < 4; k++) begin
      tick();
      idx = onehot_idx(gnt_o);
      if (idx != -1) begin
        chk($sformatf("fair_gnt%0d", g), idx, (g % 2 == 0) ? 0 : 32);
        g++;
      end
    end
    chk("fair_count", g, 4);

    do_reset("bp");
    enable_i = 1'b1;
    for (int c = 0; c < 6; c++) set_pix(3, c, 2'($urandom_range(1, 3)));
    gcnt = 0;
    repeat (12) begin
      tick();
      if (gnt_o != 0) gcnt++;
    end
    chk("bp_grants", gcnt, 4);
    chk("bp_level",  fifo_level_o, 4);
    chk("bp_busy",   busy_o, 1);
    ev_ready_i = 1'b1; pops = 0; ymask = '0;
    for (int k = 0; k < 40; k++) begin
      if (ev_valid_o && ev_ready_i) begin
        pops++;
        ymask[ev_data_o[TS_W+1 +: COL_AW]] = 1'b1;
      end
      tick();
      if (gnt_o != 0) gcnt++;
      if (gcnt >= 6) req_i = '0;
    end
    chk("bp_total_grants", gcnt, 6);
    chk("bp_pops",    pops, 6);
    chk("bp_cols",    ymask, 8'h3f);
    chk("bp_drained", fifo_level_o, 0);

    do_reset("en");
    enable_i = 1'b1;
    for (int c = 1; c <= 4; c++) set_pix(2, c, 2'b01);
    repeat (3) tick();
    chk("en_first_gnt", gnt_o, 64'd1 << 17);
    enable_i = 1'b0;
    tick();
    chk("en_no_gnt", gnt_o, 0);
    chk("en_busy",   busy_o, 0);
    chk("en_level",  fifo_level_o, 1);
    repeat (3) begin
      tick();
      chk("en_held", fifo_level_o, 1);
    end
    ev_ready_i = 1'b1;
    tick();
    chk("en_drained", fifo_level_o, 0);
    enable_i = 1'b1;
    repeat (3) tick();
    chk("en_resume_gnt", gnt_o, 64'd1 << 18);
    req_i = '0;
    repeat (4) tick();

    do_reset("wrap");
    repeat (1021) tick();
    enable_i = 1'b1; set_pix(5, 1, 2'b01); set_pix(5, 2, 2'b01);
    repeat (4) tick();
    chk("wrap_head",  ev_data_o, {3'd5, 3'd1, 1'b1, 10'h3ff});
    chk("wrap_level", fifo_level_o, 2);
    req_i = '0; ev_ready_i = 1'b1;
    tick();
    chk("wrap_next", ev_data_o, {3'd5, 3'd2, 1'b1, 10'h000});

    ev_ready_i = 1'b0;
    for (int c = 0; c < COLS; c++) set_pix(6, c, 2'b10);
    repeat (6) tick();
    #2;
    do_reset("mid");

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0)
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            set_pix(r, c, ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      enable_i   = ($urandom_range(0, 19) != 0);
      ev_ready_i = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
